// File: rtl/pc_mac_swap.sv
// TX-path stage: swaps Ethernet DA/SA on packet start beats, drops orphan beats,
// counts forwarded packets and framing errors behind a 2-entry output buffer.
module pc_mac_swap #(
  parameter bit          ENABLE_SWAP = 1'b1,
  parameter int unsigned PKT_CNT_W   = 32,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [5:0]           in_empty,
  input  logic [511:0]         in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [5:0]           out_empty,
  output logic [511:0]         out_data,
  input  logic                 out_ready,
  output logic [PKT_CNT_W-1:0] pkt_cnt,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned DATA_W  = 512;
  localparam int unsigned EMPTY_W = 6;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } beat_t;

  state_t state, state_nxt;
  logic   acc_c, pop_c, fwd_c, err_c;
  beat_t  in_beat_c;
  beat_t  head_q, tail_q, head_n, tail_n;
  logic   head_vld_q, tail_vld_q, head_vld_n, tail_vld_n;
  logic   rdy_q;

  assign in_ready  = rdy_q;
  assign out_valid = head_vld_q;
  assign out_sop   = head_q.sop;
  assign out_eop   = head_q.eop;
  assign out_empty = head_q.empty;
  assign out_data  = head_q.data;

  assign acc_c = in_valid & rdy_q;
  assign pop_c = head_vld_q & out_ready;

  // Framing FSM state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc_c) begin
      case (state)
        IDLE:    if (in_sop) state_nxt = in_eop ? IDLE : IN_PKT;
        IN_PKT:  state_nxt = in_eop ? IDLE : IN_PKT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A sop inside a packet truncates the previous one but still starts a new packet
  always_comb begin
    fwd_c = 1'b0;
    err_c = 1'b0;
    if (acc_c) begin
      case (state)
        IDLE: begin
          fwd_c = in_sop;
          err_c = ~in_sop;
        end
        IN_PKT: begin
          fwd_c = 1'b1;
          err_c = in_sop;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_beat_c.sop   = in_sop;
    in_beat_c.eop   = in_eop;
    in_beat_c.empty = in_empty;
    in_beat_c.data  = in_data;
    if (ENABLE_SWAP && in_sop) begin
      in_beat_c.data[511:464] = in_data[463:416];
      in_beat_c.data[463:416] = in_data[511:464];
    end
  end

  // Two-entry FIFO: head drives out_*, tail holds the beat behind it
  always_comb begin
    head_n     = head_q;
    tail_n     = tail_q;
    head_vld_n = head_vld_q;
    tail_vld_n = tail_vld_q;
    if (pop_c) begin
      head_n     = tail_q;
      head_vld_n = tail_vld_q;
      tail_vld_n = 1'b0;
    end
    if (fwd_c) begin
      if (!head_vld_n) begin
        head_n     = in_beat_c;
        head_vld_n = 1'b1;
      end else begin
        tail_n     = in_beat_c;
        tail_vld_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      head_q     <= head_n;
      tail_q     <= tail_n;
      head_vld_q <= head_vld_n;
      tail_vld_q <= tail_vld_n;
      rdy_q      <= ~(head_vld_n & tail_vld_n);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (pop_c && head_q.eop) pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
      if (err_c && (err_cnt != {ERR_CNT_W{1'b1}})) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_mac_swap.sv
// Scoreboard bench for pc_mac_swap: swap-enabled and swap-disabled instances share stimulus.
module tb_pc_mac_swap;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
    logic [511:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [5:0]   in_empty = '0;
  logic [511:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         in_ready0, out_valid0, out_sop0, out_eop0;
  logic [5:0]   out_empty0;
  logic [511:0] out_data0;
  logic [31:0]  pkt_cnt0;
  logic [15:0]  err_cnt0;
  logic         in_ready1, out_valid1, out_sop1, out_eop1;
  logic [5:0]   out_empty1;
  logic [511:0] out_data1;
  logic [31:0]  pkt_cnt1;
  logic [15:0]  err_cnt1;

  pc_mac_swap #(.ENABLE_SWAP(1'b1), .PKT_CNT_W(32), .ERR_CNT_W(16)) dut0 (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_data(in_data), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_sop(out_sop0), .out_eop(out_eop0), .out_empty(out_empty0), .out_data(out_data0),
    .out_ready(out_ready), .pkt_cnt(pkt_cnt0), .err_cnt(err_cnt0));

  pc_mac_swap #(.ENABLE_SWAP(1'b0), .PKT_CNT_W(32), .ERR_CNT_W(16)) dut1 (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_data(in_data), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_sop(out_sop1), .out_eop(out_eop1), .out_empty(out_empty1), .out_data(out_data1),
    .out_ready(out_ready), .pkt_cnt(pkt_cnt1), .err_cnt(err_cnt1));

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  beat_t q0[$];
  beat_t q1[$];
  beat_t mon0, mon1, held0;
  bit    stall0 = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [519:0] act, input logic [519:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] swp(input logic [511:0] d);
    logic [511:0] r;
    r = d;
    r[511:464] = d[463:416];
    r[463:416] = d[511:464];
    return r;
  endfunction

  // Monitor, swap-enabled instance: output order plus stability under backpressure
  always @(negedge clk) begin
    mon0 = '{out_sop0, out_eop0, out_empty0, out_data0};
    if (stall0 && out_valid0) chk("hold0", mon0, held0);
    stall0 = out_valid0 && !out_ready;
    held0  = mon0;
    if (out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL extra0: got %h want none", mon0);
      end else chk("beat0", mon0, q0.pop_front());
    end
  end

  // Monitor, swap-disabled instance
  always @(negedge clk) begin
    mon1 = '{out_sop1, out_eop1, out_empty1, out_data1};
    if (out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL extra1: got %h want none", mon1);
      end else chk("beat1", mon1, q1.pop_front());
    end
  end

  task automatic send(input logic sop, input logic eop, input logic [5:0] emp,
                      input logic [511:0] d, input bit fwd);
    int n;
    bit a;
    n = 0;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_empty = emp; in_data = d;
    if (fwd) begin
      q0.push_back('{sop, eop, emp, sop ? swp(d) : d});
      q1.push_back('{sop, eop, emp, d});
    end
    forever begin
      a = in_ready0;
      @(posedge clk); #1;
      if (a) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_timeout: got in_ready=0 want 1");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    chk("drain", 520'(q0.size() + q1.size()), 520'(0));
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    chk("rst_vld", out_valid0, 1'b0);
    chk("rst_rdy", in_ready0, 1'b0);
    chk("rst_pkt", pkt_cnt0, 32'd0);
    chk("rst_err", err_cnt0, 16'd0);
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy_up", in_ready0, 1'b1);
  endtask

  function automatic logic [511:0] pat(input int i);
    return {16{32'(32'hA5A5_0000 + i)}};
  endfunction

  logic [511:0] d1;
  int           c0;

  initial begin
    d1 = {48'h001122334455, 48'h66778899AABB, {13{32'hDEADBEEF}}};

    // Single-beat packet: swap, latency, counters, pass-through in the unswapped build
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 1'b1, 6'd10, d1, 1'b1);
    chk("s1_lat", out_valid0, 1'b1);
    chk("s1_da", out_data0[511:464], 48'h66778899AABB);
    chk("s1_sa", out_data0[463:416], 48'h001122334455);
    chk("s1_empty", out_empty0, 6'd10);
    chk("s1_noswap", out_data1, d1);
    drain();
    chk("s1_pkt", pkt_cnt0, 32'd1);
    chk("s1_err", err_cnt0, 16'd0);

    // 4-beat packet at full rate
    do_reset();
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 4; i++) send(i == 0, i == 3, (i == 3) ? 6'd3 : 6'd0, pat(i), 1'b1);
    chk("s2_thru", 520'(cyc - c0), 520'(4));
    drain();
    chk("s2_pkt", pkt_cnt0, 32'd1);

    // Backpressure: two beats fill the buffer, rest wait
    do_reset();
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send(i == 0, i == 3, 6'd0, pat(i + 8), 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("s3_rdy", in_ready0, 1'b0);
        chk("s3_vld", out_valid0, 1'b1);
        chk("s3_head", out_data0, swp(pat(8)));
        out_ready = 1'b1;
      end
    join
    drain();
    chk("s3_pkt", pkt_cnt0, 32'd1);

    // Orphan beat dropped
    do_reset();
    out_ready = 1'b1;
    send(1'b0, 1'b0, 6'd0, pat(20), 1'b0);
    send(1'b1, 1'b0, 6'd0, pat(21), 1'b1);
    send(1'b0, 1'b1, 6'd5, pat(22), 1'b1);
    drain();
    chk("s4_err", err_cnt0, 16'd1);
    chk("s4_pkt", pkt_cnt0, 32'd1);

    // Truncated packet A followed by single-beat B
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 1'b0, 6'd0, pat(30), 1'b1);
    send(1'b0, 1'b0, 6'd0, pat(31), 1'b1);
    send(1'b1, 1'b1, 6'd7, d1, 1'b1);
    drain();
    chk("s5_err", err_cnt0, 16'd1);
    chk("s5_pkt", pkt_cnt0, 32'd1);

    // Reset with two beats buffered mid-packet, then a clean packet
    out_ready = 1'b0;
    send(1'b1, 1'b0, 6'd0, pat(40), 1'b1);
    send(1'b0, 1'b0, 6'd0, pat(41), 1'b1);
    chk("s6_full", out_valid0, 1'b1);
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 1'b0, 6'd0, pat(42), 1'b1);
    send(1'b0, 1'b1, 6'd1, pat(43), 1'b1);
    drain();
    chk("s6_pkt", pkt_cnt0, 32'd1);
    chk("s6_err", err_cnt0, 16'd0);
    chk("s6_pkt1", pkt_cnt1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_mac_swap.md
Name: pc_mac_swap

Overview:
- Streaming stage on the 512-bit Avalon-ST TX path, directly downstream of the loopback/skid output and upstream of the MAC TX port.
- On the first beat of each packet it swaps the Ethernet destination and source MAC addresses, so looped frames return to the sender.
- Drops beats that arrive outside any packet (orphan beats) and counts forwarded packets and framing errors.
- Full-throughput ready/valid with a 2-entry output buffer, so backpressure never stalls a beat in flight.

Parameters:
- ENABLE_SWAP, 1, 1 = swap MACs on the sop beat; 0 = pass data unmodified (counting and framing checks stay active).
- PKT_CNT_W, 32, width of the forwarded-packet counter.
- ERR_CNT_W, 16, width of the framing-error counter, which saturates.

Ports:
- clk  in  1  single clock for all logic.
- arst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_sop  in  1  input start of packet.
- in_eop  in  1  input end of packet.
- in_empty  in  6  empty bytes on the eop beat.
- in_data  in  512  input data; byte 0 is at [511:504].
- in_ready  out  1  stage can accept a beat.
- out_valid  out  1  output beat valid.
- out_sop  out  1  output start of packet.
- out_eop  out  1  output end of packet.
- out_empty  out  6  output empty bytes.
- out_data  out  512  output data.
- out_ready  in  1  downstream accepts the beat.
- pkt_cnt  out  PKT_CNT_W  packets forwarded (eop beats accepted downstream); wraps.
- err_cnt  out  ERR_CNT_W  framing errors; saturates at all-ones.

Behaviour:
- Reset:
  - Asynchronous, active-low; asserting arst_n low clears state immediately.
  - All outputs go to 0 except in_ready, which is 1 once reset is released.
  - FSM goes to IDLE, buffer is empty, both counters are 0.
  - Reset in mid-packet discards all buffered beats; no partial packet resumes after reset.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A beat leaves when out_valid & out_ready.
  - in_ready = buffer occupancy < 2, registered.
  - in_ready never depends combinationally on out_ready.
- Latency: an accepted beat appears on out_* on the next cycle when the buffer is empty and out_ready=1.
- Throughput: one beat/cycle sustained with out_ready held high.
- Buffer:
  - 2 entries, FIFO order.
  - Accept and emit in the same cycle leave occupancy unchanged.
  - Accepting while occupancy is 1 and out_ready=0 takes occupancy to 2 and deasserts in_ready on the next cycle.
- FSM, states IDLE and IN_PKT, updated on accepted beats only:
  - IDLE, sop=1, eop=0: forward the beat, go to IN_PKT.
  - IDLE, sop=1, eop=1: forward the single-beat packet, stay in IDLE.
  - IDLE, sop=0: drop the beat (not written to the buffer), err_cnt+1, stay in IDLE.
  - IN_PKT, sop=0: forward the beat; eop=1 returns the FSM to IDLE.
  - IN_PKT, sop=1: the previous packet is truncated. err_cnt+1, the beat is forwarded as a new packet start, and the next state follows the beat's eop.
- Swap (ENABLE_SWAP=1, applied to sop beats only):
  - out_data[511:464] = in_data[463:416].
  - out_data[463:416] = in_data[511:464].
  - All other bits pass unchanged.
  - Non-sop beats are never modified.
  - in_empty passes through unchanged on every beat.
- Counters:
  - pkt_cnt increments when out_valid & out_ready & out_eop.
  - err_cnt increments once per error event and holds at 2^ERR_CNT_W-1.
  - The truncated packet is never counted by pkt_cnt.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold stable.

Test Plan:
- Reset, then a single beat (sop=1, eop=1, data[511:464]=0x001122334455, data[463:416]=0x66778899AABB, empty=10) with out_ready=1 -> one cycle later the output beat has [511:464]=0x66778899AABB, [463:416]=0x001122334455, empty=10; pkt_cnt=1, err_cnt=0.
- 4-beat packet, out_ready held 1 -> 4 output beats on consecutive cycles; only beat 0 is swapped, beats 1-3 are bit-identical to input; pkt_cnt=1.
- Continuous in_valid, out_ready=0 for 5 cycles -> in_ready falls after 2 accepted beats, outputs hold stable; after release all beats emerge in order with no loss or duplication.
- Orphan beat (sop=0) in IDLE, then a valid 2-beat packet -> orphan absent from output, err_cnt=1, pkt_cnt=1.
- Packet A sop plus one middle beat, then packet B sop/eop (A's eop missing) -> output shows A's 2 beats then B swapped; err_cnt=1, pkt_cnt=1.
- Drive arst_n low with 2 beats buffered mid-packet -> out_valid=0 immediately, counters 0; a new packet after reset passes normally.
- ENABLE_SWAP=0 build, repeat the first scenario -> output data equals input data exactly.
